// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder (dmem_responder).
package dmem_pkg;
   localparam int WORD_WIDTH  = 32;
   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;
   localparam int CNT_WIDTH   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmemState_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and dmem_responder (slave).
// Both channels: a transfer happens on a posedge where valid && ready; valid never waits on ready.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [WORD_WIDTH-1:0] req_addr;
   logic [WORD_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [WORD_WIDTH-1:0] resp_rdata;
   logic                  resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with registered read data; contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int  DEPTH_WORDS = 256,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  we,
   input  logic [IDX_W-1:0]      index,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata
);

   logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (en && we) mem[index] <= wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)          rdata <= '0;
      else if (en && !we)  rdata <= mem[index];
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with pipeline stall output.
// Optional address checking is enabled by defining DMEM_ERROR_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic             clock,
   input  logic             reset,
   dmem_responder_if.slave  bus,
   output logic             stall,
   output dmemState_t       dbgState
);

   localparam int                   IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

   dmemState_t            state, nextState;
   logic [CNT_WIDTH-1:0]  countdown;
   logic                  readyReg;
   logic                  accept;
   logic                  reqError;
   logic                  holdWrite;
   logic                  holdError;
   logic [IDX_W-1:0]      holdIndex;
   logic [WORD_WIDTH-1:0] holdWdata;
   logic [WORD_WIDTH-1:0] ramRdata;
   logic                  commitEn;
   logic                  unusedAddrBits;

   assign accept = bus.req_valid && readyReg;

`ifdef DMEM_ERROR_CHECK_EN
   assign reqError = (bus.req_addr[1:0] != 2'b00) ||
                     (bus.req_addr >= WORD_WIDTH'(4 * DEPTH_WORDS));
`else
   assign reqError = 1'b0;
`endif

   // Byte-offset and above-array bits never reach the RAM index.
   assign unusedAddrBits = ^{bus.req_addr[WORD_WIDTH-1:IDX_W+2], bus.req_addr[1:0]};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = WAIT;
         WAIT:    if (countdown == '0) nextState = RESP;
         RESP:    if (bus.resp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // WAIT is always entered, so the commit edge lands exactly LATENCY edges after acceptance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         readyReg  <= 1'b0;
         countdown <= '0;
         holdWrite <= 1'b0;
         holdError <= 1'b0;
         holdIndex <= '0;
         holdWdata <= '0;
      end else begin
         readyReg <= (nextState == IDLE);
         if (accept) begin
            countdown <= CNT_LOAD;
            holdWrite <= bus.req_write;
            holdError <= reqError;
            holdIndex <= bus.req_addr[IDX_W+1:2];
            holdWdata <= bus.req_wdata;
         end else if (state == WAIT && countdown != '0) begin
            countdown <= countdown - 1'b1;
         end
      end
   end

   always_comb begin
      stall          = (state != IDLE);
      commitEn       = (state == WAIT) && (countdown == '0) && !holdError;
      bus.resp_valid = 1'b0;
      bus.resp_error = 1'b0;
      bus.resp_rdata = '0;
      if (state == RESP) begin
         bus.resp_valid = 1'b1;
         bus.resp_error = holdError;
         if (!holdWrite && !holdError) bus.resp_rdata = ramRdata;
      end
   end

   assign bus.req_ready = readyReg;
   assign dbgState      = state;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) wordArray (
      .clock (clock),
      .reset (reset),
      .en    (commitEn),
      .we    (holdWrite),
      .index (holdIndex),
      .wdata (holdWdata),
      .rdata (ramRdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, reset-in-WAIT sequence, random traffic
// against a word-map model, and a LATENCY=1 throughput instance.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;
`ifdef DMEM_ERROR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       stall, stall1;
   dmemState_t dbg, dbg1;

   dmem_responder_if busA();
   dmem_responder_if busB();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .bus(busA), .stall(stall), .dbgState(dbg)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clock(clock), .reset(reset), .bus(busB), .stall(stall1), .dbgState(dbg1)
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   // Model memory: word index -> last committed store value.
   logic [31:0] refMem [int];

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      int          hold;
      logic [31:0] expRd;
      logic        expErr;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] expRd, output logic expErr, output bit known);
      int idx;
      expErr = ERR_EN && ((a % 32'd4) != 32'd0 || a >= 32'(4 * DEPTH));
      idx    = int'((a / 32'd4) % 32'(DEPTH));
      expRd  = '0;
      known  = 1'b1;
      if (expErr) return;
      if (w) refMem[idx] = d;
      else if (refMem.exists(idx)) expRd = refMem[idx];
      else known = 1'b0;
   endfunction

   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                      input logic [31:0] expRd, input logic expErr, input bit known);
      int lat;
      check("req_ready_idle", 32'(busA.req_ready), 32'd1);
      busA.req_valid = 1'b1;
      busA.req_write = w;
      busA.req_addr  = a;
      busA.req_wdata = d;
      @(posedge clock);
      @(negedge clock);
      lat = 0;
      while (!busA.resp_valid && lat < 40) begin
         busA.req_valid = ($urandom_range(0, 1) == 1);
         busA.req_write = ($urandom_range(0, 1) == 1);
         busA.req_addr  = $urandom;
         busA.req_wdata = $urandom;
         check("stall_wait", 32'(stall), 32'd1);
         check("req_ready_wait", 32'(busA.req_ready), 32'd0);
         @(posedge clock);
         @(negedge clock);
         lat++;
      end
      check("resp_valid_rise", 32'(busA.resp_valid), 32'd1);
      check("latency", 32'(lat), 32'(LAT));
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) begin
            @(posedge clock);
            @(negedge clock);
         end
         check("resp_valid_hold", 32'(busA.resp_valid), 32'd1);
         check("resp_error", 32'(busA.resp_error), 32'(expErr));
         if (known) check("resp_rdata", busA.resp_rdata, expRd);
         check("stall_resp", 32'(stall), 32'd1);
         check("req_ready_resp", 32'(busA.req_ready), 32'd0);
      end
      busA.req_valid  = 1'b0;
      busA.resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      busA.resp_ready = 1'b0;
      check("post_resp_valid", 32'(busA.resp_valid), 32'd0);
      check("post_req_ready", 32'(busA.req_ready), 32'd1);
      check("post_stall", 32'(stall), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(busA.req_ready), 32'd0);
      check({tag, "_resp_valid"}, 32'(busA.resp_valid), 32'd0);
      check({tag, "_resp_rdata"}, busA.resp_rdata, 32'd0);
      check({tag, "_resp_error"}, 32'(busA.resp_error), 32'd0);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_state"}, 32'(dbg), 32'(IDLE));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] expRd, a, d;
      logic        expErr, w;
      bit          known;

      busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_addr = '0;
      busA.req_wdata = '0;   busA.resp_ready = 1'b0;
      busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_addr = '0;
      busB.req_wdata = '0;   busB.resp_ready = 1'b0;

      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      check("reset1_req_ready", 32'(busB.req_ready), 32'd0);
      check("reset1_stall", 32'(stall1), 32'd0);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);

      vecs[0] = '{1'b1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_0012, 32'hCAFE_F00D, 0, 32'h0, ERR_EN};
      vecs[4] = '{1'b1, 32'h0000_0400, 32'h0000_0005, 2, 32'h0, ERR_EN};
      vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,         0, ERR_EN ? 32'hDEAD_BEEF : 32'hCAFE_F00D, 1'b0};
      vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,         0, ERR_EN ? 32'h1111_1111 : 32'h0000_0005, 1'b0};
      vecs[7] = '{1'b0, 32'h0000_0012, 32'h0,         1, ERR_EN ? 32'h0 : 32'hCAFE_F00D, ERR_EN};

      for (int i = 0; i < 8; i++) begin
         model(vecs[i].w, vecs[i].a, vecs[i].d, expRd, expErr, known);
         txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold, vecs[i].expRd, vecs[i].expErr, 1'b1);
      end

      // Reset while a store is in WAIT: the store must be discarded.
      model(1'b1, 32'h20, 32'hA5A5_A5A5, expRd, expErr, known);
      txn(1'b1, 32'h20, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 1'b1);
      busA.req_valid = 1'b1; busA.req_write = 1'b1;
      busA.req_addr  = 32'h20; busA.req_wdata = 32'h0000_1234;
      @(posedge clock);
      @(negedge clock);
      busA.req_valid = 1'b0;
      check("rst_pre_state", 32'(dbg), 32'(WAIT));
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      model(1'b0, 32'h20, 32'h0, expRd, expErr, known);
      txn(1'b0, 32'h20, 32'h0, 0, expRd, expErr, known);

      for (int n = 0; n < 40; n++) begin
         w = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 7))
            0:       a = $urandom;
            1:       a = 32'($urandom_range(0, 15)) * 32'd4 + 32'h40 + 32'($urandom_range(1, 3));
            2:       a = 32'($urandom_range(0, 15)) * 32'd4 + 32'h440;
            default: a = 32'($urandom_range(0, 15)) * 32'd4 + 32'h40;
         endcase
         d = $urandom;
         model(w, a, d, expRd, expErr, known);
         txn(w, a, d, $urandom_range(0, 3), expRd, expErr, known);
      end

      // LATENCY=1, continuous loads with resp_ready high: WAIT, RESP, IDLE repeating.
      check("l1_req_ready", 32'(busB.req_ready), 32'd1);
      busB.req_valid  = 1'b1;
      busB.req_write  = 1'b0;
      busB.req_addr   = 32'($urandom_range(0, 255)) * 32'd4;
      busB.resp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock);
         @(negedge clock);
         busB.req_addr = 32'($urandom_range(0, 255)) * 32'd4;
         check("l1_stall", 32'(stall1), 32'((i % 3) != 2));
         check("l1_resp_valid", 32'(busB.resp_valid), 32'((i % 3) == 1));
         check("l1_req_ready_cyc", 32'(busB.req_ready), 32'((i % 3) == 2));
      end
      busB.req_valid  = 1'b0;
      busB.resp_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
